fb_arb_mem_responder: RTL and testbench
=======================================

Name: fb_arb_mem_responder

Overview:
- Responder end of the arbiter request interface that the drawing data-gen engines drive (rts/rtr, wben, addr, data, op).
- Buffers accepted requests in a small FIFO and issues them one per cycle to a synchronous framebuffer SRAM port.
- Returns read data to all clients on a broadcast bus (data + one-cycle xfc pulse).
- Sits between the arbiter output mux and the framebuffer memory.

Parameters:
- AW, 16, address width (word address)
- DEPTH, 4, request FIFO depth (power of 2, >= 2)

Ports:
- clk  input  1  system clock
- rst_  input  1  reset; asynchronous, active-low
- arb_in_rts  input  1  requester has a valid request
- arb_out_rtr  output  1  responder can accept a request
- arb_in_wben  input  4  byte write enables; bit i covers data[8i+7:8i]
- arb_in_addr  input  AW  word address
- arb_in_data  input  32  write data
- arb_in_op  input  1  0 = write, 1 = read
- arb_bcast_out_data  output  32  read return data
- arb_bcast_out_xfc  output  1  one-cycle pulse; bcast data valid
- mem_en  output  1  SRAM access enable
- mem_we  output  4  SRAM byte write enables
- mem_addr  output  AW  SRAM address
- mem_wdata  output  32  SRAM write data
- mem_rdata  input  32  SRAM read data, valid the cycle after a read access
- resp_is_idle  output  1  FIFO empty and no read in flight

Behaviour:
- Transfer: occurs on a rising edge where arb_in_rts & arb_out_rtr. Only then are wben/addr/data/op sampled.
- arb_out_rtr = !full, combinational from the occupancy count.
  - When full, no push is allowed, even if a pop happens in the same cycle.
- FIFO:
  - DEPTH entries of {op, wben, addr, data}, with read/write pointers and count of width clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
- Issue:
  - On each edge where the FIFO is non-empty, pop the head and register it onto the mem_* outputs.
  - Max throughput is 1 request/cycle.
  - Minimum latency: accept at edge E0 -> mem_* driven after edge E1.
- Write entry (op=0):
  - mem_en=1, mem_we=wben, mem_addr=addr, mem_wdata=data.
  - If wben==0, the entry is popped but dropped: mem_en=0, no access.
- Read entry (op=1):
  - mem_en=1, mem_we=0, mem_addr=addr; mem_wdata holds its previous value.
  - A one-bit read-pending flag is set.
- Read return: the edge after a read issue captures mem_rdata into arb_bcast_out_data and pulses arb_bcast_out_xfc for exactly one cycle.
  - Read latency from accept to xfc is 2 cycles minimum.
  - Back-to-back reads give back-to-back xfc pulses.
  - arb_bcast_out_data holds its last value between pulses.
- Idle cycles (FIFO empty): mem_en=0 and mem_we=0; mem_addr and mem_wdata hold.
- Ordering: strict FIFO order. A read following a write to the same address returns the written data.
- resp_is_idle = (count==0) & !read_pending & !mem_en. It is combinational and is used by engines for pipeline stall decisions.
- Reset values:
  - arb_out_rtr=1 (combinational from count=0), arb_bcast_out_data=0, arb_bcast_out_xfc=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_is_idle=1.
  - Pointers, count and read_pending are all 0.
- Reset mid-operation: all FIFO contents and any in-flight read are discarded, and no xfc is produced for them.
- No state machine beyond FIFO and read pipeline; the two-state issue logic is {EMPTY, ISSUING}, derived from count.

Test Plan:
- Single write (rts 1 cycle): wben=4'h3, addr=16'h0010, data=32'hAABBCCDD, op=0 -> one cycle later mem_en=1, mem_we=4'h3, mem_addr=16'h0010, mem_wdata=32'hAABBCCDD; no bcast xfc.
- Backpressure:
  - Hold rts=1 with 6 writes while mem_* is observed -> rtr never drops (1/cycle drain).
  - Then stall the FIFO by forcing it full with DEPTH=4 and a held reset-free burst against a test-only pop disable -> rtr=0 at count=4, exactly 4 accepted.
- Write then read of addr 16'h00F0, data 32'h12345678, with an SRAM model -> exactly one xfc pulse 2 cycles after the read accept; bcast data=32'h12345678.
- Three back-to-back reads of addrs 1,2,3 -> three consecutive xfc pulses, data in order.
- Write with wben=4'h0 -> no mem_en assertion; FIFO empties; resp_is_idle returns to 1.
- Assert rst_ low while 3 entries are queued and a read is in flight -> no xfc; all outputs at reset values immediately (async); after release, rtr=1 and resp_is_idle=1.

Source files
------------

// File: rtl/fb_arb_mem_responder.sv
// Arbiter-side responder: queues engine requests in a small FIFO, issues one per
// cycle to a synchronous framebuffer SRAM port and broadcasts read data back.
module fb_arb_mem_responder #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          arb_in_rts,
  output logic          arb_out_rtr,
  input  logic [3:0]    arb_in_wben,
  input  logic [AW-1:0] arb_in_addr,
  input  logic [31:0]   arb_in_data,
  input  logic          arb_in_op,
  output logic [31:0]   arb_bcast_out_data,
  output logic          arb_bcast_out_xfc,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          resp_is_idle,
  input  logic          tst_pop_dis
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_ISSUING = 1'b1
  } issue_st_e;

  typedef struct packed {
    logic          op;
    logic [3:0]    wben;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } req_t;

  req_t          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          mem_en_q, mem_en_d;
  logic [3:0]    mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          rd_pend_q, rd_pend_d;
  logic [31:0]   bcast_data_q, bcast_data_d;
  logic          bcast_xfc_q, bcast_xfc_d;

  issue_st_e     issue_st_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  req_t          head_s;
  req_t          req_in_s;

  assign full_s   = (count_q == CNT_FULL);
  assign push_s   = arb_in_rts & ~full_s;
  assign head_s   = fifo_q[rd_ptr_q];
  assign req_in_s = '{op: arb_in_op, wben: arb_in_wben, addr: arb_in_addr, data: arb_in_data};

  // The issue "state" is purely a view of the occupancy count.
  always_comb begin
    issue_st_s = ST_EMPTY;
    if (count_q != CNT_ZERO) begin
      issue_st_s = ST_ISSUING;
    end else begin
      issue_st_s = ST_EMPTY;
    end
  end

  // Pointer/count next state and issue decode of the FIFO head.
  always_comb begin
    pop_s       = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'h0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_pend_d   = 1'b0;
    case (issue_st_s)
      ST_ISSUING: begin
        pop_s = ~tst_pop_dis;
        if (pop_s && head_s.op) begin
          mem_en_d   = 1'b1;
          mem_addr_d = head_s.addr;
          rd_pend_d  = 1'b1;
        end else if (pop_s && (head_s.wben != 4'h0)) begin
          mem_en_d    = 1'b1;
          mem_we_d    = head_s.wben;
          mem_addr_d  = head_s.addr;
          mem_wdata_d = head_s.data;
        end else begin
          // zero-byte-enable writes are consumed without touching the SRAM
          mem_en_d = 1'b0;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase

    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (rd_pend_q) begin
      bcast_data_d = mem_rdata;
      bcast_xfc_d  = 1'b1;
    end else begin
      bcast_data_d = bcast_data_q;
      bcast_xfc_d  = 1'b0;
    end
  end

  // FIFO storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= req_in_s;
    end
  end

  // Control, SRAM port and broadcast registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= CNT_ZERO;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 4'h0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= 32'h0;
      rd_pend_q    <= 1'b0;
      bcast_data_q <= 32'h0;
      bcast_xfc_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_pend_q    <= rd_pend_d;
      bcast_data_q <= bcast_data_d;
      bcast_xfc_q  <= bcast_xfc_d;
    end
  end

  assign arb_out_rtr        = ~full_s;
  assign mem_en             = mem_en_q;
  assign mem_we             = mem_we_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;
  assign arb_bcast_out_data = bcast_data_q;
  assign arb_bcast_out_xfc  = bcast_xfc_q;
  assign resp_is_idle       = (count_q == CNT_ZERO) & ~rd_pend_q & ~mem_en_q;

endmodule

// File: tb/tb_fb_arb_mem_responder.sv
// Directed bench for fb_arb_mem_responder: SRAM model plus queue scoreboard of
// expected SRAM accesses and broadcast read data.
module tb_fb_arb_mem_responder;

  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_;
  logic          arb_in_rts;
  logic          arb_out_rtr;
  logic [3:0]    arb_in_wben;
  logic [AW-1:0] arb_in_addr;
  logic [31:0]   arb_in_data;
  logic          arb_in_op;
  logic [31:0]   arb_bcast_out_data;
  logic          arb_bcast_out_xfc;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          resp_is_idle;
  logic          tst_pop_dis;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  mem_exp_t    exp_mem[$];
  logic [31:0] exp_rd[$];
  logic [31:0] sram      [256];
  logic [31:0] model_mem [256];

  always #5 clk = ~clk;

  fb_arb_mem_responder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_),
    .arb_in_rts(arb_in_rts), .arb_out_rtr(arb_out_rtr),
    .arb_in_wben(arb_in_wben), .arb_in_addr(arb_in_addr),
    .arb_in_data(arb_in_data), .arb_in_op(arb_in_op),
    .arb_bcast_out_data(arb_bcast_out_data), .arb_bcast_out_xfc(arb_bcast_out_xfc),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .resp_is_idle(resp_is_idle), .tst_pop_dis(tst_pop_dis)
  );

  // SRAM: byte-masked synchronous write, read data presented for the addressed word
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end
  assign mem_rdata = sram[mem_addr[7:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every SRAM access and every broadcast must match the queue head
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      chk("mem_expected", 64'(exp_mem.size() != 0), 64'd1);
      if (exp_mem.size() != 0) begin
        mem_exp_t e;
        e = exp_mem.pop_front();
        chk("mem_we", 64'(mem_we), 64'(e.we));
        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        if (e.we != 4'h0) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
      end
    end
    if (arb_bcast_out_xfc === 1'b1) begin
      chk("xfc_expected", 64'(exp_rd.size() != 0), 64'd1);
      if (exp_rd.size() != 0) begin
        logic [31:0] d;
        d = exp_rd.pop_front();
        chk("bcast_data", 64'(arb_bcast_out_data), 64'(d));
      end
    end
  end

  task automatic drive(input logic op, input logic [3:0] wben, input logic [15:0] addr,
                       input logic [31:0] data, output logic acc);
    @(negedge clk);
    arb_in_rts  = 1'b1;
    arb_in_op   = op;
    arb_in_wben = wben;
    arb_in_addr = addr;
    arb_in_data = data;
    #1;
    acc = arb_out_rtr;
    @(posedge clk);
    if (acc) begin
      if (op) begin
        exp_mem.push_back('{we: 4'h0, addr: addr, wdata: 32'h0});
        exp_rd.push_back(model_mem[addr[7:0]]);
      end else if (wben != 4'h0) begin
        exp_mem.push_back('{we: wben, addr: addr, wdata: data});
        for (int b = 0; b < 4; b++) begin
          if (wben[b]) model_mem[addr[7:0]][8*b +: 8] = data[8*b +: 8];
        end
      end
    end
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL timeout simulation did not complete");
  end

  initial begin
    logic acc;
    int   n_acc;
    for (int i = 0; i < 256; i++) begin
      sram[i]      = 32'hC0DE_0000 | 32'(i);
      model_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    rst_ = 1'b0; arb_in_rts = 1'b0; arb_in_op = 1'b0; arb_in_wben = 4'h0;
    arb_in_addr = 16'h0; arb_in_data = 32'h0; tst_pop_dis = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rtr", 64'(arb_out_rtr), 64'd1);
    chk("rst_idle", 64'(resp_is_idle), 64'd1);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_bcast", 64'(arb_bcast_out_data), 64'd0);
    chk("rst_xfc", 64'(arb_bcast_out_xfc), 64'd0);
    rst_ = 1'b1;

    // single write: issued one cycle after the accept edge
    drive(1'b0, 4'h3, 16'h0010, 32'hAABBCCDD, acc);
    chk("wr_acc", 64'(acc), 64'd1);
    @(negedge clk); arb_in_rts = 1'b0;
    chk("wr_not_yet", 64'(mem_en), 64'd0);
    chk("wr_busy", 64'(resp_is_idle), 64'd0);
    @(negedge clk);
    chk("wr_issue_en", 64'(mem_en), 64'd1);
    chk("wr_issue_we", 64'(mem_we), 64'h3);
    chk("wr_no_xfc", 64'(arb_bcast_out_xfc), 64'd0);
    @(negedge clk);
    chk("wr_done_en", 64'(mem_en), 64'd0);
    chk("wr_addr_hold", 64'(mem_addr), 64'h0010);
    chk("wr_wdata_hold", 64'(mem_wdata), 64'hAABBCCDD);
    chk("wr_idle", 64'(resp_is_idle), 64'd1);

    // streaming writes drain at one per cycle, rtr never drops
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'hF, 16'h0020 + 16'(i), 32'h1000_0000 + 32'(i * 32'h111), acc);
      chk("bp_rtr", 64'(acc), 64'd1);
    end
    @(negedge clk); arb_in_rts = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_drained", 64'(exp_mem.size()), 64'd0);

    // pop disabled: exactly DEPTH accepted, then rtr low
    tst_pop_dis = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'hF, 16'h0040 + 16'(i), 32'h4000_0000 + 32'(i), acc);
      n_acc += int'(acc);
    end
    @(negedge clk);
    chk("full_rtr", 64'(arb_out_rtr), 64'd0);
    chk("full_count", 64'(n_acc), 64'(DEPTH));
    chk("full_no_issue", 64'(mem_en), 64'd0);
    // pop resumes while rts stays high: the full FIFO must still refuse this edge
    tst_pop_dis = 1'b0;
    @(negedge clk); arb_in_rts = 1'b0;
    chk("full_pop_rtr", 64'(arb_out_rtr), 64'd1);
    chk("full_pop_en", 64'(mem_en), 64'd1);
    repeat (5) @(negedge clk);
    chk("full_drained", 64'(exp_mem.size()), 64'd0);
    chk("full_idle", 64'(resp_is_idle), 64'd1);

    // write then read same address: xfc two cycles after the read accept
    drive(1'b0, 4'hF, 16'h00F0, 32'h12345678, acc);
    drive(1'b1, 4'h0, 16'h00F0, 32'h0, acc);
    @(negedge clk); arb_in_rts = 1'b0;
    chk("rd_xfc_e0", 64'(arb_bcast_out_xfc), 64'd0);
    @(negedge clk);
    chk("rd_xfc_e1", 64'(arb_bcast_out_xfc), 64'd0);
    @(negedge clk);
    chk("rd_xfc_e2", 64'(arb_bcast_out_xfc), 64'd1);
    chk("rd_data", 64'(arb_bcast_out_data), 64'h12345678);
    @(negedge clk);
    chk("rd_xfc_e3", 64'(arb_bcast_out_xfc), 64'd0);
    chk("rd_data_hold", 64'(arb_bcast_out_data), 64'h12345678);

    // three back-to-back reads give three consecutive xfc pulses in order
    for (int i = 1; i <= 3; i++) drive(1'b1, 4'h0, 16'(i), 32'h0, acc);
    @(negedge clk); arb_in_rts = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("b2b_xfc", 64'(arb_bcast_out_xfc), 64'd1);
      chk("b2b_data", 64'(arb_bcast_out_data), 64'(32'hC0DE_0000 | 32'(i)));
      @(negedge clk);
    end
    chk("b2b_xfc_end", 64'(arb_bcast_out_xfc), 64'd0);

    // zero byte enables: entry consumed, no SRAM access
    drive(1'b0, 4'h0, 16'h0077, 32'hDEADBEEF, acc);
    @(negedge clk); arb_in_rts = 1'b0;
    chk("wb0_busy", 64'(resp_is_idle), 64'd0);
    @(negedge clk);
    chk("wb0_no_en", 64'(mem_en), 64'd0);
    chk("wb0_idle", 64'(resp_is_idle), 64'd1);
    chk("sb_mem_empty", 64'(exp_mem.size()), 64'd0);
    chk("sb_rd_empty", 64'(exp_rd.size()), 64'd0);

    // reset with a read in flight and three entries queued
    tst_pop_dis = 1'b1;
    drive(1'b1, 4'h0, 16'h0005, 32'h0, acc);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'hF, 16'h0090 + 16'(i), 32'h9000_0000, acc);
    @(negedge clk); arb_in_rts = 1'b0; tst_pop_dis = 1'b0;
    @(negedge clk);
    #2;
    chk("mid_rd_issued", 64'(mem_en), 64'd1);
    rst_ = 1'b0;
    #1;
    exp_mem.delete();
    exp_rd.delete();
    chk("mid_rst_en", 64'(mem_en), 64'd0);
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_wdata", 64'(mem_wdata), 64'd0);
    chk("mid_rst_bcast", 64'(arb_bcast_out_data), 64'd0);
    chk("mid_rst_xfc", 64'(arb_bcast_out_xfc), 64'd0);
    chk("mid_rst_rtr", 64'(arb_out_rtr), 64'd1);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    chk("post_rst_rtr", 64'(arb_out_rtr), 64'd1);
    chk("post_rst_idle", 64'(resp_is_idle), 64'd1);
    repeat (4) @(negedge clk);
    chk("post_rst_no_en", 64'(mem_en), 64'd0);
    chk("post_rst_no_xfc", 64'(arb_bcast_out_xfc), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
